button_press_decoder: RTL and testbench

//  Consumer end of the button debouncer pulse interface. It counts debounced press pulses

---
 rtl/button_press_decoder_pkg.sv | 19 +
 rtl/button_press_decoder_ena_gap_timer.sv | 40 ++++
 rtl/button_press_decoder.sv | 113 +++++++++++
 tb/tb_button_press_decoder.sv | 195 +++++++++++++++++++
 4 files changed

// File: rtl/button_press_decoder_pkg.sv
// Shared definitions for the button press decoder and its neighbours.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Holds the FSM state encoding and the default tick constants that the
// clock-set control logic also reuses.
package button_press_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_COUNT = 2'd1,
    ST_EMIT  = 2'd2
  } state_t;

  // 150 ticks of the 2 ms enable = 300 ms of silence closes a burst.
  localparam int TICK_2MS_GAP     = 150;
  localparam int MAX_PRESSES_DFLT = 5;

endpackage

// File: rtl/button_press_decoder_ena_gap_timer.sv
// Gap timer: counts enable ticks since the last clear, flags the final tick.
// Latency: o_expire is combinational on the tick where gap==GAP_TICKS-1.
// Backpressure: none; i_clr always wins over counting.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_ena         enable tick; gap advances only on these cycles
//   i_clr         forces gap to 0 (press seen, or decoder not counting)
//   o_expire      gap==GAP_TICKS-1 on an enable tick without i_clr
module ena_gap_timer #(
  parameter int GAP_TICKS = 150,
  parameter int GAP_W     = 8
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_ena,
  input  logic i_clr,
  output logic o_expire
);

  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(GAP_TICKS - 1);

  logic [GAP_W-1:0] gap;
  logic             at_last;

  assign at_last  = (gap == GAP_LAST);
  assign o_expire = i_ena & ~i_clr & at_last;

  // Wrap to 0 on expiry so gap never exceeds GAP_TICKS-1.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      gap <= '0;
    end else if (i_clr) begin
      gap <= '0;
    end else if (i_ena) begin
      gap <= at_last ? '0 : gap + GAP_W'(1);
    end
  end

endmodule

// File: rtl/button_press_decoder.sv
// Counts debounced press bursts and reports the count once the button goes quiet.
// Latency: o_valid GAP_TICKS enable ticks after the last press, plus one clock.
// Backpressure: none; o_valid is a one-clock strobe, results held until the next one.
//
// Ports:
//   i_clk, i_rst  clock, synchronous active-high reset
//   i_ena         enable tick shared with the debouncer
//   i_pulse       debounced press, high for one enable period per press
//   o_valid       one-clock strobe when a burst closes
//   o_count       press count of the last closed burst (1..MAX_PRESSES)
//   o_overflow    last closed burst exceeded MAX_PRESSES
//   o_busy        burst in progress (including the emit cycle)
module button_press_decoder
  import button_press_decoder_pkg::*;
#(
  parameter int GAP_TICKS   = TICK_2MS_GAP,
  parameter int MAX_PRESSES = MAX_PRESSES_DFLT,
  parameter int CNT_W       = 3,
  parameter int GAP_W       = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_ena,
  input  logic             i_pulse,
  output logic             o_valid,
  output logic [CNT_W-1:0] o_count,
  output logic             o_overflow,
  output logic             o_busy
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_PRESSES);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic             ovf;
  logic             press;
  logic             gap_clr;
  logic             gap_expire;

  // i_pulse spans a whole enable period, so gating with i_ena sees each press once.
  assign press = i_pulse & i_ena;

  // Keep the gap timer parked at 0 whenever we are not actively counting, so
  // every entry into COUNT (from IDLE or EMIT) starts a fresh gap.
  assign gap_clr = press | (state != ST_COUNT);

  ena_gap_timer #(
    .GAP_TICKS (GAP_TICKS),
    .GAP_W     (GAP_W)
  ) u_gap_timer (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_ena    (i_ena),
    .i_clr    (gap_clr),
    .o_expire (gap_expire)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      ovf        <= 1'b0;
      o_valid    <= 1'b0;
      o_count    <= '0;
      o_overflow <= 1'b0;
      o_busy     <= 1'b0;
    end else begin
      o_valid <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (press) begin
            cnt    <= CNT_ONE;
            ovf    <= 1'b0;
            state  <= ST_COUNT;
            o_busy <= 1'b1;
          end
        end
        ST_COUNT: begin
          // A press on the expiry tick wins: gap_expire is masked by gap_clr.
          if (press) begin
            if (cnt < CNT_MAX) begin
              cnt <= cnt + CNT_ONE;
            end else begin
              ovf <= 1'b1;
            end
          end else if (gap_expire) begin
            state      <= ST_EMIT;
            o_valid    <= 1'b1;
            o_count    <= cnt;
            o_overflow <= ovf;
          end
        end
        ST_EMIT: begin
          // A press landing in the emit cycle opens the next burst directly.
          if (press) begin
            cnt   <= CNT_ONE;
            ovf   <= 1'b0;
            state <= ST_COUNT;
          end else begin
            state  <= ST_IDLE;
            o_busy <= 1'b0;
          end
        end
        default: begin
          state  <= ST_IDLE;
          o_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_button_press_decoder.sv
// Directed bench for button_press_decoder with GAP_TICKS=4, MAX_PRESSES=5,
// and i_ena on every 4th clock.
module tb_button_press_decoder;

  logic       i_clk;
  logic       i_rst;
  logic       i_ena;
  logic       i_pulse;
  logic       o_valid;
  logic [2:0] o_count;
  logic       o_overflow;
  logic       o_busy;

  int nvec = 0;
  int nerr = 0;
  int cyc = 0;
  int last_press = 0;

  // Record of every o_valid strobe seen.
  int         vq_cyc[$];
  logic [2:0] vq_cnt[$];
  logic       vq_ovf[$];
  logic       vq_busy[$];

  button_press_decoder #(
    .GAP_TICKS   (4),
    .MAX_PRESSES (5),
    .CNT_W       (3),
    .GAP_W       (8)
  ) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_ena      (i_ena),
    .i_pulse    (i_pulse),
    .o_valid    (o_valid),
    .o_count    (o_count),
    .o_overflow (o_overflow),
    .o_busy     (o_busy)
  );

  initial begin
    i_clk = 1'b0;
    forever #5 i_clk = ~i_clk;
  end

  // One clock: drive inputs, take the edge, sample 1 time unit later.
  task automatic clk1(input logic rst, input logic ena, input logic pulse);
    i_rst   = rst;
    i_ena   = ena;
    i_pulse = pulse;
    @(posedge i_clk);
    #1;
    cyc++;
    if (!rst && ena && pulse) last_press = cyc;
    if (o_valid === 1'b1) begin
      vq_cyc.push_back(cyc);
      vq_cnt.push_back(o_count);
      vq_ovf.push_back(o_overflow);
      vq_busy.push_back(o_busy);
    end
  endtask

  // One enable period: 4 clocks, enable on the last, pulse held throughout.
  task automatic tick(input logic press);
    for (int k = 0; k < 4; k++) clk1(1'b0, (k == 3), press);
  endtask

  task automatic clear_mon();
    vq_cyc.delete();
    vq_cnt.delete();
    vq_ovf.delete();
    vq_busy.delete();
  endtask

  task automatic test_reset();
    clk1(1'b1, 1'b0, 1'b0);
    clk1(1'b1, 1'b0, 1'b0);
    nvec++; if (o_valid !== 1'b0) begin nerr++; $display("FAIL rst_valid got %b exp 0", o_valid); end
    nvec++; if (o_count !== 3'd0) begin nerr++; $display("FAIL rst_count got %0d exp 0", o_count); end
    nvec++; if (o_overflow !== 1'b0) begin nerr++; $display("FAIL rst_ovf got %b exp 0", o_overflow); end
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL rst_busy got %b exp 0", o_busy); end
    tick(1'b1);
    tick(1'b1);
    nvec++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL rst_pre_busy got %b exp 1", o_busy); end
    clear_mon();
    for (int k = 0; k < 3; k++) clk1(1'b1, 1'b0, 1'b0);
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL rst_mid_busy got %b exp 0", o_busy); end
    nvec++; if (o_count !== 3'd0) begin nerr++; $display("FAIL rst_mid_count got %0d exp 0", o_count); end
    for (int k = 0; k < 6; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 0) begin nerr++; $display("FAIL rst_no_valid got %0d strobes exp 0", vq_cyc.size()); end
  endtask

  task automatic test_single();
    clear_mon();
    tick(1'b1);
    for (int k = 0; k < 6; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 1) begin nerr++; $display("FAIL single_nvalid got %0d exp 1", vq_cyc.size()); end
    nvec++; if (vq_cnt[0] !== 3'd1) begin nerr++; $display("FAIL single_count got %0d exp 1", vq_cnt[0]); end
    nvec++; if (vq_ovf[0] !== 1'b0) begin nerr++; $display("FAIL single_ovf got %b exp 0", vq_ovf[0]); end
    nvec++; if (vq_cyc[0] - last_press != 16) begin nerr++; $display("FAIL single_latency got %0d exp 16", vq_cyc[0] - last_press); end
    nvec++; if (vq_busy[0] !== 1'b1) begin nerr++; $display("FAIL single_emit_busy got %b exp 1", vq_busy[0]); end
    nvec++; if (o_count !== 3'd1 || o_valid !== 1'b0) begin nerr++; $display("FAIL single_hold got count %0d valid %b exp 1 0", o_count, o_valid); end
  endtask

  task automatic test_press_at_expire();
    clear_mon();
    tick(1'b1);
    for (int k = 0; k < 3; k++) tick(1'b0);
    tick(1'b1);
    nvec++; if (o_busy !== 1'b1 || vq_cyc.size() != 0) begin nerr++; $display("FAIL expire_press got busy %b strobes %0d exp 1 0", o_busy, vq_cyc.size()); end
    for (int k = 0; k < 6; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 1 || vq_cnt[0] !== 3'd2) begin nerr++; $display("FAIL expire_count got %0d strobes count %0d exp 1 2", vq_cyc.size(), vq_cnt[0]); end
  endtask

  task automatic test_three();
    bit pat [0:8];
    int busy_bad;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    busy_bad = 0;
    clear_mon();
    for (int i = 0; i < 9; i++) begin
      tick(pat[i]);
      if (vq_cyc.size() == 0 && o_busy !== 1'b1) busy_bad++;
    end
    nvec++; if (busy_bad != 0) begin nerr++; $display("FAIL three_busy got %0d idle ticks exp 0", busy_bad); end
    nvec++; if (vq_cyc.size() != 1) begin nerr++; $display("FAIL three_nvalid got %0d exp 1", vq_cyc.size()); end
    nvec++; if (vq_cnt[0] !== 3'd3 || vq_ovf[0] !== 1'b0) begin nerr++; $display("FAIL three_count got %0d/%b exp 3/0", vq_cnt[0], vq_ovf[0]); end
    nvec++; if (vq_busy[0] !== 1'b1) begin nerr++; $display("FAIL three_emit_busy got %b exp 1", vq_busy[0]); end
    nvec++; if (vq_cyc[0] - last_press != 16) begin nerr++; $display("FAIL three_latency got %0d exp 16", vq_cyc[0] - last_press); end
    tick(1'b0);
    nvec++; if (o_busy !== 1'b0) begin nerr++; $display("FAIL three_idle_busy got %b exp 0", o_busy); end
  endtask

  task automatic test_overflow();
    clear_mon();
    for (int k = 0; k < 7; k++) tick(1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 1) begin nerr++; $display("FAIL ovf_nvalid got %0d exp 1", vq_cyc.size()); end
    nvec++; if (vq_cnt[0] !== 3'd5 || vq_ovf[0] !== 1'b1) begin nerr++; $display("FAIL ovf_count got %0d/%b exp 5/1", vq_cnt[0], vq_ovf[0]); end
    nvec++; if (o_overflow !== 1'b1 || o_count !== 3'd5) begin nerr++; $display("FAIL ovf_hold got %0d/%b exp 5/1", o_count, o_overflow); end
    clear_mon();
    for (int k = 0; k < 2; k++) tick(1'b1);
    for (int k = 0; k < 5; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 1 || vq_cnt[0] !== 3'd2 || vq_ovf[0] !== 1'b0) begin
      nerr++; $display("FAIL ovf_next got %0d strobes %0d/%b exp 1 2/0", vq_cyc.size(), vq_cnt[0], vq_ovf[0]);
    end
  endtask

  task automatic test_emit_press();
    clear_mon();
    tick(1'b1);
    tick(1'b1);
    for (int k = 0; k < 4; k++) tick(1'b0);
    nvec++; if (o_valid !== 1'b1 || vq_cyc.size() != 1) begin nerr++; $display("FAIL emit_valid got %b strobes %0d exp 1 1", o_valid, vq_cyc.size()); end
    clk1(1'b0, 1'b1, 1'b1);
    nvec++; if (o_valid !== 1'b0 || o_busy !== 1'b1) begin nerr++; $display("FAIL emit_after got valid %b busy %b exp 0 1", o_valid, o_busy); end
    nvec++; if (vq_cnt[0] !== 3'd2) begin nerr++; $display("FAIL emit_old_count got %0d exp 2", vq_cnt[0]); end
    for (int k = 0; k < 5; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 2) begin nerr++; $display("FAIL emit_nvalid got %0d exp 2", vq_cyc.size()); end
    nvec++; if (vq_cnt[1] !== 3'd1 || vq_ovf[1] !== 1'b0) begin nerr++; $display("FAIL emit_new_count got %0d/%b exp 1/0", vq_cnt[1], vq_ovf[1]); end
    nvec++; if (vq_cyc[1] - last_press != 16) begin nerr++; $display("FAIL emit_latency got %0d exp 16", vq_cyc[1] - last_press); end
  endtask

  task automatic test_no_ena_and_rst();
    clear_mon();
    for (int k = 0; k < 10; k++) clk1(1'b0, 1'b0, 1'b1);
    nvec++; if (o_busy !== 1'b0 || vq_cyc.size() != 0) begin nerr++; $display("FAIL noena got busy %b strobes %0d exp 0 0", o_busy, vq_cyc.size()); end
    nvec++; if (o_count !== 3'd1) begin nerr++; $display("FAIL noena_count got %0d exp 1", o_count); end
    tick(1'b1);
    tick(1'b1);
    tick(1'b0);
    nvec++; if (o_busy !== 1'b1) begin nerr++; $display("FAIL midrst_pre got busy %b exp 1", o_busy); end
    clk1(1'b1, 1'b0, 1'b0);
    clk1(1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 6; k++) tick(1'b0);
    nvec++; if (vq_cyc.size() != 0) begin nerr++; $display("FAIL midrst_valid got %0d strobes exp 0", vq_cyc.size()); end
    nvec++; if (o_count !== 3'd0 || o_busy !== 1'b0) begin nerr++; $display("FAIL midrst_state got count %0d busy %b exp 0 0", o_count, o_busy); end
  endtask

  initial begin
    i_rst   = 1'b1;
    i_ena   = 1'b0;
    i_pulse = 1'b0;
    test_reset();
    test_single();
    test_press_at_expire();
    test_three();
    test_overflow();
    test_emit_press();
    test_no_ena_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
